// File: rtl/wbuffer_tagpool.sv
// Tag allocator for the write buffer: offers one free tag at a time in round-robin
// order, takes tags back by mask or by index, and tracks how many are in use.
module wbuffer_tagpool #(
    parameter int NUM_TAGS = 32,
    parameter int TAG_W    = $clog2(NUM_TAGS),
    parameter int LOW_WM   = 4
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                tag_valid,
    output logic [TAG_W-1:0]    tag,
    input  logic                tag_enable,
    input  logic [NUM_TAGS-1:0] tag_free,
    input  logic                free_valid,
    input  logic [TAG_W-1:0]    free_tag,
    input  logic                flush,
    output logic [TAG_W:0]      used_cnt,
    output logic                tags_low,
    output logic                err_bad_free
);

    // Per-tag state is encoded without an explicit enum:
    // state   | encoding
    // FREE    | used_q[i]=0 and not the offered tag
    // OFFERED | tag_valid=1 and tag==i (at most one)
    // USED    | used_q[i]=1
    logic [NUM_TAGS-1:0] used_q;
    logic [TAG_W-1:0]    rr_ptr_q;

    logic                hs;
    logic [NUM_TAGS-1:0] ret_mask;
    logic [NUM_TAGS-1:0] legal_mask;
    logic [NUM_TAGS-1:0] grant_mask;
    logic [NUM_TAGS-1:0] hold_mask;
    logic [NUM_TAGS-1:0] used_d;
    logic [NUM_TAGS-1:0] free_post;
    logic                bad_free;
    logic                need_offer;

    logic                pick_found;
    logic [TAG_W-1:0]    pick_idx;
    logic [TAG_W:0]      ret_cnt;
    logic [TAG_W:0]      used_cnt_d;
    logic [TAG_W+1:0]    avail;

    always_comb begin
        hs         = tag_valid & tag_enable;
        need_offer = ~tag_valid | tag_enable;

        ret_mask = tag_free;
        if (free_valid) begin
            ret_mask[free_tag] = 1'b1;
        end

        // Only USED tags may come back; a FREE or OFFERED return is flagged and dropped.
        legal_mask = ret_mask & used_q;
        bad_free   = |(ret_mask & ~used_q);

        grant_mask = '0;
        if (hs) begin
            grant_mask[tag] = 1'b1;
        end

        hold_mask = '0;
        if (tag_valid && !tag_enable) begin
            hold_mask[tag] = 1'b1;
        end

        used_d    = (used_q & ~legal_mask) | grant_mask;
        free_post = ~used_d & ~hold_mask;
    end

    // Round-robin search over the post-return free set, starting at rr_ptr.
    always_comb begin
        logic [TAG_W-1:0] idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            idx = rr_ptr_q + TAG_W'(i);
            if (!pick_found && free_post[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_comb begin
        ret_cnt = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            ret_cnt = ret_cnt + (TAG_W+1)'(legal_mask[i]);
        end
        used_cnt_d = used_cnt + (TAG_W+1)'(hs) - ret_cnt;
    end

    always_comb begin
        avail    = (TAG_W+2)'(NUM_TAGS) - {1'b0, used_cnt};
        tags_low = (avail <= (TAG_W+2)'(LOW_WM));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_valid    <= 1'b0;
            tag          <= '1;
            used_q       <= '0;
            rr_ptr_q     <= '0;
            used_cnt     <= '0;
            err_bad_free <= 1'b0;
        end else if (flush) begin
            // Sticky error survives a flush; only reset clears it.
            tag_valid <= 1'b0;
            used_q    <= '0;
            rr_ptr_q  <= '0;
            used_cnt  <= '0;
        end else begin
            used_q   <= used_d;
            used_cnt <= used_cnt_d;
            if (bad_free) begin
                err_bad_free <= 1'b1;
            end
            if (need_offer) begin
                if (pick_found) begin
                    tag_valid <= 1'b1;
                    tag       <= pick_idx;
                    rr_ptr_q  <= pick_idx + TAG_W'(1);
                end else begin
                    tag_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/wbuffer_tagpool.md
WBUFFER_TAGPOOL -- requirements
Module: wbuffer_tagpool

Interface
REQ-001 The block SHALL have parameter NUM_TAGS, default 32, total tag count, a power of two in the range 4..256.
REQ-002 The block SHALL have parameter TAG_W, default $clog2(NUM_TAGS), tag index width.
REQ-003 The block SHALL have parameter LOW_WM, default 4, free-tag low-watermark threshold.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock, rising-edge.
REQ-005 The block SHALL have port rstn, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port tag_valid, output, 1 bit, a tag is offered on tag.
REQ-007 The block SHALL have port tag, output, TAG_W bits, the offered tag index.
REQ-008 The block SHALL have port tag_enable, input, 1 bit, the consumer takes the offered tag this cycle.
REQ-009 The block SHALL have port tag_free, input, NUM_TAGS bits, a one-cycle-per-bit mask of tags being returned.
REQ-010 The block SHALL have port free_valid, input, 1 bit, an indexed single-tag return.
REQ-011 The block SHALL have port free_tag, input, TAG_W bits, the index for free_valid.
REQ-012 The block SHALL have port flush, input, 1 bit, a synchronous release of all tags.
REQ-013 The block SHALL have port used_cnt, output, TAG_W+1 bits, the count of consumed, unreturned tags.
REQ-014 The block SHALL have port tags_low, output, 1 bit, asserted when (NUM_TAGS - used_cnt) <= LOW_WM.
REQ-015 The block SHALL have port err_bad_free, output, 1 bit, a sticky illegal-return flag.

Function
REQ-016 The block SHALL hold a per-tag state: FREE, OFFERED (reserved on the output, at most one tag) or USED.
REQ-017 The block SHALL register tag_valid and tag, and a handshake SHALL occur on a cycle with tag_valid && tag_enable; on that cycle the offered tag SHALL become USED at the next edge.
REQ-018 The block SHALL ignore tag_enable while tag_valid=0.
REQ-019 While tag_valid=1 and tag_enable=0, the block SHALL hold tag and tag_valid stable.
REQ-020 The effective returns of a cycle SHALL be tag_free OR the one-hot of free_tag when free_valid=1, and each returned tag in state USED SHALL become FREE at the next edge.
REQ-021 Selection SHALL use the post-return state, so a tag returned in cycle N SHALL be offerable on the output in cycle N+1.
REQ-022 Whenever the output is empty or consumed this cycle, the block SHALL choose the next offer by round-robin: the first FREE index at or after rr_ptr, wrapping modulo NUM_TAGS.
REQ-023 On each new offer, the block SHALL update rr_ptr to the offered index + 1, wrapping to 0 after NUM_TAGS-1.
REQ-024 When no FREE tag exists, the block SHALL drive tag_valid to 0 at the next edge and SHALL keep tag at its last value.
REQ-025 The block SHALL register used_cnt, increment it by 1 per handshake and decrement it by the number of legal returns, with both applied in the same cycle; used_cnt SHALL never exceed NUM_TAGS-1 plus the offered tag, and SHALL never underflow.
REQ-026 The block SHALL compute tags_low combinationally from the registered used_cnt.
REQ-027 A returned tag in state FREE or OFFERED SHALL be illegal; the block SHALL ignore that return and set err_bad_free at the next edge, and err_bad_free SHALL be cleared only by reset.
REQ-028 When the same tag is in tag_free and in free_tag on the same cycle, the block SHALL count it as one legal return.
REQ-029 A handshake and a return of a different tag on the same cycle SHALL both take effect.
REQ-030 flush=1 SHALL have priority over handshake, returns and selection.
REQ-031 At the edge following flush=1, all tags SHALL be FREE, used_cnt=0, rr_ptr=0 and tag_valid=0, and any handshake on the flush cycle SHALL be discarded.
REQ-032 The first offer after a flush SHALL appear one cycle after flush deasserts, as tag 0.

Reset
REQ-033 On rstn=0, the block SHALL asynchronously set tag_valid=0, tag=all-ones, all tags FREE, rr_ptr=0, used_cnt=0 and err_bad_free=0, and tags_low SHALL follow (0 when LOW_WM < NUM_TAGS).
REQ-034 At the first rising edge with rstn=1, the block SHALL set tag_valid=1 and tag=0.
REQ-035 A reset asserted mid-operation SHALL discard all state, including any in-progress handshake.

Verification
REQ-036 The bench SHALL cover: reset release, then tag_enable=1 held for 32 cycles with NUM_TAGS=32 -> tags 0,1,...,31 granted on consecutive cycles, tag_valid=0 afterward, used_cnt=32, tags_low=1.
REQ-037 The bench SHALL cover: all tags used, then free_valid=1 with free_tag=7 in cycle N -> tag_valid=1 and tag=7 in cycle N+1, and used_cnt=31 at N+1.
REQ-038 The bench SHALL cover: tags 0..3 consumed, then tag 1 freed via tag_free -> the next grants are 4,5,... and tag 1 is reissued only after the wrap past 31.
REQ-039 The bench SHALL cover: a return of FREE tag 20, then a return of the currently OFFERED tag -> err_bad_free=1 sticky with used_cnt unchanged.
REQ-040 The bench SHALL cover: a handshake and a return of another tag in the same cycle -> used_cnt unchanged, and a tag_free/free_tag overlap on one tag -> used_cnt decrements by 1.
REQ-041 The bench SHALL cover: 10 tags used, then a one-cycle flush pulse concurrent with tag_enable -> used_cnt=0, tag_valid=0 for one cycle, then tag=0 offered.
